dmem_dump_arbiter: RTL

- Shares the single-port data memory between the MEM stage and the debug unit.
- In normal operation it passes MEM-stage accesses straight through to the memory.
- On a debug dump request it stalls the pipeline, reads a contiguous address range word by word, and streams the words to the debug unit over a valid/ready handshake. It then releases the pipeline.
- It sits between the MEM stage and the data-memory RAM: asynchronous read, synchronous write.

---
 rtl/dmem_dump_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dmem_dump_arbiter.sv
// rtl/dmem_dump_arbiter.sv - data-memory arbiter between the MEM stage and the debug dump engine
module dmem_dump_arbiter #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               clk,
  input  logic               i_rst,
  // MEM-stage side
  input  logic               i_pipe_we,
  input  logic [NB_ADDR-1:0] i_pipe_addr,
  input  logic [NB_DATA-1:0] i_pipe_wdata,
  output logic [NB_DATA-1:0] o_pipe_rdata,
  output logic               o_pipe_stall,
  // debug unit side
  input  logic               i_dbg_start,
  input  logic [NB_ADDR-1:0] i_dbg_base,
  input  logic [NB_ADDR-1:0] i_dbg_count,
  output logic [NB_DATA-1:0] o_dbg_data,
  output logic               o_dbg_valid,
  input  logic               i_dbg_ready,
  output logic               o_dbg_last,
  output logic               o_dbg_busy,
  output logic               o_dbg_done,
  // data-memory RAM side
  output logic               o_mem_we,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB_DATA-1:0] o_mem_wdata,
  input  logic [NB_DATA-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // A count of zero requests the whole memory, which needs one extra bit.
  localparam logic [NB_ADDR:0] REM_FULL = (NB_ADDR+1)'(1) << NB_ADDR;
  localparam logic [NB_ADDR:0] REM_ONE  = (NB_ADDR+1)'(1);

  state_t             r_state;
  state_t             w_state_next;
  logic [NB_ADDR-1:0] r_ptr;
  logic [NB_ADDR-1:0] w_ptr_next;
  logic [NB_ADDR:0]   r_rem;
  logic [NB_ADDR:0]   w_rem_next;
  logic [NB_DATA-1:0] r_dbg_data;
  logic [NB_DATA-1:0] w_dbg_data_next;
  logic               r_dbg_valid;
  logic               w_dbg_valid_next;

  logic               w_idle;
  logic               w_rem_one;
  logic               w_handshake;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_rem_one   = (r_rem == REM_ONE);
  assign w_handshake = r_dbg_valid & i_dbg_ready;

  // State and dump datapath registers; reset drops everything back to IDLE at once.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_rem       <= '0;
      r_dbg_data  <= '0;
      r_dbg_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_ptr       <= w_ptr_next;
      r_rem       <= w_rem_next;
      r_dbg_data  <= w_dbg_data_next;
      r_dbg_valid <= w_dbg_valid_next;
    end
  end

  // Next-state and next-datapath decode: one word is captured in LOAD and
  // held in PRESENT until the debug unit takes it.
  always_comb begin
    w_state_next     = r_state;
    w_ptr_next       = r_ptr;
    w_rem_next       = r_rem;
    w_dbg_data_next  = r_dbg_data;
    w_dbg_valid_next = r_dbg_valid;
    case (r_state)
      ST_IDLE: begin
        if (i_dbg_start) begin
          w_ptr_next   = i_dbg_base;
          w_rem_next   = (i_dbg_count == '0) ? REM_FULL : {1'b0, i_dbg_count};
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_dbg_data_next  = i_mem_rdata;
        w_dbg_valid_next = 1'b1;
        w_state_next     = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (w_handshake) begin
          w_dbg_valid_next = 1'b0;
          if (w_rem_one) begin
            w_state_next = ST_DONE;
          end else begin
            w_ptr_next   = r_ptr + 1'b1;
            w_rem_next   = r_rem - REM_ONE;
            w_state_next = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Memory mux: the pipeline owns the RAM only in IDLE; stores are gated otherwise
  // and also while reset is held.
  always_comb begin
    o_mem_addr  = w_idle ? i_pipe_addr : r_ptr;
    o_mem_wdata = i_pipe_wdata;
    o_mem_we    = w_idle & i_pipe_we & ~i_rst;
  end

  // Status outputs decoded from registered state only.
  always_comb begin
    o_pipe_rdata = i_mem_rdata;
    o_pipe_stall = ~w_idle;
    o_dbg_busy   = ~w_idle;
    o_dbg_done   = (r_state == ST_DONE);
    o_dbg_data   = r_dbg_data;
    o_dbg_valid  = r_dbg_valid;
    o_dbg_last   = r_dbg_valid & w_rem_one;
  end

endmodule
